// File: rtl/inter_pred_seq_if.sv
// Downstream handshake bundle of inter_pred_seq: averager capture strobe,
// block valid/ready handshake, current block index and macroblock-done pulse.
interface inter_pred_seq_if;
   logic       avg_capture;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] blk_idx;
   logic       mb_done;

   modport master (
      output avg_capture,
      output out_valid,
      output blk_idx,
      output mb_done,
      input  out_ready
   );

   modport slave (
      input  avg_capture,
      input  out_valid,
      input  blk_idx,
      input  mb_done,
      output out_ready
   );
endinterface

// File: rtl/inter_pred_seq.sv
// Inter-prediction block sequencer: for each 4x4 block of a macroblock it
// launches the L0/L1 interpolators, waits for every used list to finish,
// strobes the averager and hands the block downstream.
// Optional feature macro: INTER_WEIGHTED_PRED_EN (registered weighted-
// prediction parameters; without it those outputs are tied to 0).
module inter_pred_seq #(
   parameter int unsigned NUM_BLK = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  mb_start,
   input  logic [1:0]            pred_dir,
   input  logic                  abort,
   input  logic                  Inter_L0_end,
   input  logic                  Inter_L1_end,
   input  logic                  wp_en_in,
   input  logic [2:0]            logWD_in,
   input  logic [7:0]            w0_in,
   input  logic [7:0]            w1_in,
   input  logic [7:0]            o0_in,
   input  logic [7:0]            o1_in,
   output logic                  Inter_L0_start,
   output logic                  Inter_L1_start,
   output logic                  enable_L0,
   output logic                  enable_L1,
   output logic                  weighted_pred_en,
   output logic [2:0]            logWD,
   output logic [7:0]            w0,
   output logic [7:0]            w1,
   output logic [7:0]            o0,
   output logic [7:0]            o1,
   inter_pred_seq_if.master      out_if
);

   localparam logic [3:0] LAST_BLK = 4'(NUM_BLK - 1);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, AVG, OUT} state_t;

   state_t     state_q, state_d;
   logic [1:0] dir_q, dir_d;
   logic [1:0] flag_q, flag_d;
   logic [3:0] blk_q, blk_d;
   logic       l0s_q, l0s_d;
   logic       l1s_q, l1s_d;
   logic       cap_q, cap_d;
   logic       val_q, val_d;
   logic       done_q, done_d;
   logic [1:0] ends;
   logic       accept;

   assign ends   = {Inter_L0_end, Inter_L1_end} & dir_q;
   assign accept = (state_q == IDLE) && mb_start && (pred_dir != 2'b00) && !abort;

   // next-state and registered-output computation; abort overrides everything
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      flag_d  = flag_q;
      blk_d   = blk_q;
      l0s_d   = 1'b0;
      l1s_d   = 1'b0;
      cap_d   = 1'b0;
      val_d   = val_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = LAUNCH;
               dir_d   = pred_dir;
               blk_d   = '0;
               flag_d  = '0;
               l0s_d   = pred_dir[1];
               l1s_d   = pred_dir[0];
            end
         end
         LAUNCH: begin
            // flags from the previous block are dropped; an end seen here counts
            flag_d  = ends;
            state_d = WAIT;
         end
         WAIT: begin
            flag_d = flag_q | ends;
            if ((flag_d & dir_q) == dir_q) begin
               state_d = AVG;
               cap_d   = 1'b1;
            end
         end
         AVG: begin
            state_d = OUT;
            val_d   = 1'b1;
         end
         OUT: begin
            if (out_if.out_ready) begin
               val_d  = 1'b0;
               flag_d = '0;
               if (blk_q == LAST_BLK) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  dir_d   = '0;
                  blk_d   = '0;
               end else begin
                  state_d = LAUNCH;
                  blk_d   = blk_q + 4'd1;
                  l0s_d   = dir_q[1];
                  l1s_d   = dir_q[0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
         dir_d   = '0;
         flag_d  = '0;
         blk_d   = '0;
         l0s_d   = 1'b0;
         l1s_d   = 1'b0;
         cap_d   = 1'b0;
         val_d   = 1'b0;
         done_d  = 1'b0;
      end
   end

   // sequencer state and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         dir_q   <= '0;
         flag_q  <= '0;
         blk_q   <= '0;
         l0s_q   <= 1'b0;
         l1s_q   <= 1'b0;
         cap_q   <= 1'b0;
         val_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         flag_q  <= flag_d;
         blk_q   <= blk_d;
         l0s_q   <= l0s_d;
         l1s_q   <= l1s_d;
         cap_q   <= cap_d;
         val_q   <= val_d;
         done_q  <= done_d;
      end
   end

   assign Inter_L0_start     = l0s_q;
   assign Inter_L1_start     = l1s_q;
   assign enable_L0          = dir_q[1];
   assign enable_L1          = dir_q[0];
   assign out_if.avg_capture = cap_q;
   assign out_if.out_valid   = val_q;
   assign out_if.blk_idx     = blk_q;
   assign out_if.mb_done     = done_q;

`ifdef INTER_WEIGHTED_PRED_EN
   logic [35:0] wp_q, wp_d;

   // parameters captured on an accepted start and held for the macroblock
   always_comb begin
      wp_d = wp_q;
      if (accept) wp_d = {wp_en_in, logWD_in, w0_in, w1_in, o0_in, o1_in};
   end

   // weighted-prediction parameter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wp_q <= '0;
      else          wp_q <= wp_d;
   end

   assign {weighted_pred_en, logWD, w0, w1, o0, o1} = wp_q;
`else
   logic unused_wp_inputs;
   assign unused_wp_inputs = ^{wp_en_in, logWD_in, w0_in, w1_in, o0_in, o1_in};
   assign {weighted_pred_en, logWD, w0, w1, o0, o1} = '0;
`endif

endmodule

// File: tb/tb_inter_pred_seq.sv
// Self-checking bench for inter_pred_seq: a scripted interpolator/downstream
// responder derives every expected output from the sequencing rules
// (start, end+1 capture, end+2 valid, handshake) with per-block randomization.
module tb_inter_pred_seq;
   localparam int unsigned NB = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       mb_start, abort, Inter_L0_end, Inter_L1_end;
   logic [1:0] pred_dir;
   logic       wp_en_in;
   logic [2:0] logWD_in;
   logic [7:0] w0_in, w1_in, o0_in, o1_in;
   logic       Inter_L0_start, Inter_L1_start, enable_L0, enable_L1;
   logic       weighted_pred_en;
   logic [2:0] logWD;
   logic [7:0] w0, w1, o0, o1;

   inter_pred_seq_if bus ();

   inter_pred_seq #(.NUM_BLK(NB)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .mb_start         (mb_start),
      .pred_dir         (pred_dir),
      .abort            (abort),
      .Inter_L0_end     (Inter_L0_end),
      .Inter_L1_end     (Inter_L1_end),
      .wp_en_in         (wp_en_in),
      .logWD_in         (logWD_in),
      .w0_in            (w0_in),
      .w1_in            (w1_in),
      .o0_in            (o0_in),
      .o1_in            (o1_in),
      .Inter_L0_start   (Inter_L0_start),
      .Inter_L1_start   (Inter_L1_start),
      .enable_L0        (enable_L0),
      .enable_L1        (enable_L1),
      .weighted_pred_en (weighted_pred_en),
      .logWD            (logWD),
      .w0               (w0),
      .w1               (w1),
      .o0               (o0),
      .o1               (o1),
      .out_if           (bus.master)
   );

   always #5 clk = ~clk;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [35:0] exp_wp;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [35:0] wp_inputs();
`ifdef INTER_WEIGHTED_PRED_EN
      return {wp_en_in, logWD_in, w0_in, w1_in, o0_in, o1_in};
`else
      return '0;
`endif
   endfunction

   task automatic shuffle_wp();
      wp_en_in = 1'($urandom);
      logWD_in = 3'($urandom);
      w0_in    = 8'($urandom);
      w1_in    = 8'($urandom);
      o0_in    = 8'($urandom);
      o1_in    = 8'($urandom);
   endtask

   task automatic check_wp(input string tag);
      check(tag, {weighted_pred_en, logWD, w0, w1, o0, o1}, exp_wp);
   endtask

   // everything quiet: no pulses, no enables, index 0
   task automatic check_idle(input string tag);
      check(tag, {Inter_L0_start, Inter_L1_start, enable_L0, enable_L1, bus.avg_capture,
                  bus.out_valid, bus.mb_done, bus.blk_idx}, 64'd0);
   endtask

   // mode: 0 normal, 1 abort in WAIT of block ib, 2 reset in WAIT of block ib
   // stall < 0 -> random 0..3 cycles of out_ready low
   task automatic run_mb(input logic [1:0] dir, input int fd0, input int fd1,
                         input int stall, input int mode, input int ib);
      int d0, d1, last, st;
      shuffle_wp();
      mb_start = 1'b1;
      pred_dir = dir;
      exp_wp   = wp_inputs();
      step();
      mb_start = 1'b0;
      pred_dir = 2'($urandom);
      shuffle_wp();
      for (int b = 0; b < int'(NB); b++) begin
         // launch cycle
         check("start", {Inter_L0_start, Inter_L1_start}, dir);
         check("launch_blk", bus.blk_idx, b);
         check("enables", {enable_L0, enable_L1}, dir);
         check("launch_quiet", {bus.avg_capture, bus.out_valid, bus.mb_done}, 0);
         check_wp("wp_hold");
         d0 = (fd0 > 0) ? fd0 : int'($urandom_range(1, 6));
         d1 = (fd1 > 0) ? fd1 : int'($urandom_range(1, 6));
         last = 0;
         if (dir[1] && d0 > last) last = d0;
         if (dir[0] && d1 > last) last = d1;
         for (int t = 1; t <= last; t++) begin
            step();
            Inter_L0_end = 1'b0;
            Inter_L1_end = 1'b0;
            mb_start     = 1'b0;
            check("wait_quiet", {Inter_L0_start, Inter_L1_start, bus.avg_capture, bus.out_valid}, 0);
            check("wait_blk", bus.blk_idx, b);
            if (t == 1 && b == ib && mode == 1) begin
               abort = 1'b1;
               step();
               abort = 1'b0;
               check_idle("abort_idle");
               check_wp("abort_wp");
               for (int i = 0; i < 4; i++) begin
                  step();
                  check_idle("post_abort");
               end
               return;
            end
            if (t == 1 && b == ib && mode == 2) begin
               reset_n = 1'b0;
               #1;
               exp_wp = '0;
               check_idle("reset_async");
               check_wp("reset_wp");
               step();
               reset_n = 1'b1;
               for (int i = 0; i < 4; i++) begin
                  step();
                  check_idle("post_reset");
               end
               return;
            end
            Inter_L0_end = dir[1] ? (t == d0) : ($urandom_range(0, 2) == 0);
            Inter_L1_end = dir[0] ? (t == d1) : ($urandom_range(0, 2) == 0);
            mb_start     = ($urandom_range(0, 3) == 0);
         end
         step();
         Inter_L0_end = 1'b0;
         Inter_L1_end = 1'b0;
         mb_start     = 1'b0;
         check("avg_capture", {bus.avg_capture, bus.out_valid}, 2'b10);
         check("avg_quiet", {Inter_L0_start, Inter_L1_start}, 0);
         st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
         for (int i = 0; i <= st; i++) begin
            step();
            bus.out_ready = (i == st);
            check("out_valid", {bus.out_valid, bus.avg_capture}, 2'b10);
            check("out_blk", bus.blk_idx, b);
            check("out_quiet", {Inter_L0_start, Inter_L1_start, bus.mb_done}, 0);
         end
         step();
         bus.out_ready = 1'b0;
         if (b == int'(NB) - 1) begin
            check("mb_done", bus.mb_done, 1);
            check("done_idle", {Inter_L0_start, Inter_L1_start, enable_L0, enable_L1,
                                bus.avg_capture, bus.out_valid, bus.blk_idx}, 0);
            step();
            check_idle("after_done");
            check_wp("after_done_wp");
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      mb_start = 1'b0; abort = 1'b0; pred_dir = 2'b00;
      Inter_L0_end = 1'b0; Inter_L1_end = 1'b0;
      bus.out_ready = 1'b0;
      shuffle_wp();
      exp_wp = '0;
      step();
      step();
      check_idle("reset_state");
      check_wp("reset_wp_state");
      reset_n = 1'b1;
      step();
      check_idle("idle_after_release");

      // single-list L0, fixed 3-cycle interpolation, no back-pressure
      run_mb(2'b10, 3, 0, 0, 0, -1);
      // both lists, ends 4 and 8 cycles after start, then simultaneous ends
      run_mb(2'b11, 4, 8, 0, 0, -1);
      run_mb(2'b11, 6, 6, 0, 0, -1);
      // L1 only with 4 cycles of downstream stall on every block
      run_mb(2'b01, 0, 0, 4, 0, -1);
      // abort in WAIT of block 5, then a clean restart
      run_mb(2'b11, 0, 0, -1, 1, 5);
      run_mb(2'b10, 0, 0, -1, 0, -1);
      // reset in WAIT of block 7
      run_mb(2'b11, 0, 0, -1, 2, 7);

      // start with no list selected is ignored and latches nothing
      shuffle_wp();
      mb_start = 1'b1;
      pred_dir = 2'b00;
      step();
      mb_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_idle("dir0_ignored");
         check_wp("dir0_wp");
      end

      for (int n = 0; n < 8; n++)
         run_mb(2'($urandom_range(1, 3)), 0, 0, -1, 0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
